// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch controller.
// Consumes the registered PC, drives the instruction-memory read handshake,
// buffers one instruction for decode and produces the next PC (npc_out),
// which the PC register loads unconditionally. Stalls are done by feeding
// the current PC back. Branch/jump redirects squash in-flight reads.
// Optional build macro: FETCH_PERF_EN adds saturating perf counters
// perf_fetch_cnt (decode transfers) and perf_squash_cnt (discarded reads
// and dropped buffered instructions).
//
// Handshakes: imem_req rises with imem_addr and both stay stable until the
// cycle imem_ack is high (the read completes on that posedge; only reset may
// withdraw a request). Decode transfer happens on a posedge where inst_valid
// and inst_ready are both high; inst_valid never drops without a transfer
// except when a redirect drops the buffered instruction.
module fetch_unit #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_in,
    output logic [AW-1:0] npc_out,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic          inst_valid,
    output logic [DW-1:0] inst_out,
    output logic [AW-1:0] inst_pc,
    input  logic          inst_ready,
    input  logic          br_valid,
    input  logic [AW-1:0] br_target,
`ifdef FETCH_PERF_EN
    output logic [15:0]   perf_fetch_cnt,
    output logic [15:0]   perf_squash_cnt,
`endif
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2,
        SQUASH  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] hold_addr;
    logic          load_buf;
    logic          drop_buf;
    logic          set_hold;

    assign state_dbg = state_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, next-PC and memory request decode
    always_comb begin
        state_d   = state_q;
        npc_out   = pc_in;
        imem_req  = 1'b0;
        imem_addr = '0;
        load_buf  = 1'b0;
        drop_buf  = 1'b0;
        set_hold  = 1'b0;
        case (state_q)
            BOOT: begin
                // PC register comes out of reset at all-ones, so +1 wraps to 0
                npc_out = pc_in + AW'(1);
                state_d = FETCH;
            end
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_in;
                if (br_valid) begin
                    npc_out = br_target;
                    if (!imem_ack) begin
                        // read still in flight: finish it at the old address
                        set_hold = 1'b1;
                        state_d  = SQUASH;
                    end
                end else if (imem_ack) begin
                    load_buf = 1'b1;
                    npc_out  = pc_in + AW'(1);
                    state_d  = DELIVER;
                end
            end
            SQUASH: begin
                imem_req  = 1'b1;
                imem_addr = hold_addr;
                if (br_valid) begin
                    npc_out = br_target;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            DELIVER: begin
                if (br_valid) begin
                    npc_out = br_target;
                end
                if (br_valid || inst_ready) begin
                    drop_buf = 1'b1;
                    state_d  = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Instruction buffer: data/PC change only on a load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
        end else if (load_buf) begin
            inst_valid <= 1'b1;
            inst_out   <= imem_rdata;
            inst_pc    <= pc_in;
        end else if (drop_buf) begin
            inst_valid <= 1'b0;
        end
    end

    // Address of the read being squashed, held while the PC moves on
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_addr <= '0;
        end else if (set_hold) begin
            hold_addr <= pc_in;
        end
    end

`ifdef FETCH_PERF_EN
    logic xfer_evt;
    logic squash_evt;

    assign xfer_evt   = inst_valid & inst_ready;
    assign squash_evt = (imem_ack & (((state_q == FETCH) & br_valid) | (state_q == SQUASH)))
                      | ((state_q == DELIVER) & br_valid & ~inst_ready);

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt  <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (xfer_evt && (perf_fetch_cnt != 16'hFFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            end
            if (squash_evt && (perf_squash_cnt != 16'hFFFF)) begin
                perf_squash_cnt <= perf_squash_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with a flag-based reference
// model of the fetch rules, a PC register closing the npc_out loop, a
// wait-state memory and a decode sink. Honours FETCH_PERF_EN.
module tb_fetch_unit;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] npc_out;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          inst_valid;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b0;
  logic          br_valid = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic [1:0]    state_dbg;
`ifdef FETCH_PERF_EN
  logic [15:0]   perf_fetch_cnt;
  logic [15:0]   perf_squash_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // reference model: booted / buffer full / squash pending
  bit            m_boot;
  bit            m_buf;
  bit            m_sq;
  logic [AW-1:0] m_sq_addr;
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_out;
  int            m_fetch;
  int            m_squash;

  // memory model and stimulus knobs
  bit            mem_busy;
  int            mem_wait;
  logic [AW-1:0] mem_addr;
  int wmin, wmax, ready_pct, br_pct, br_mode;
  bit fired, saw_040, saw_1ff, saw_wrap;

  fetch_unit #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .npc_out(npc_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .br_valid(br_valid),
    .br_target(br_target),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_squash_cnt(perf_squash_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // PC register: reset to all-ones, loads npc_out every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_in <= '1;
    else      pc_in <= npc_out;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_boot = 0; m_buf = 0; m_sq = 0;
    m_sq_addr = '0; m_pc = '0; m_out = '0;
    m_fetch = 0; m_squash = 0;
    mem_busy = 0; mem_wait = 0;
    exp_q.delete();
  endtask

  // asserts reset asynchronously, checks cleared outputs, releases after hold posedges
  task automatic apply_reset(input int hold);
    rst = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0; br_valid = 1'b0; br_target = '0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst_out", inst_out, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_pc_reg", pc_in, 9'h1FF);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 0);
    check("rst_perf_squash", perf_squash_cnt, 0);
`endif
    model_reset();
    repeat (hold) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // driver + model for one cycle; entered and left at posedge+1
  task automatic cycle();
    logic [AW-1:0] e_npc, e_addr, tgt;
    logic          e_req;
    bit            rdy, br;
    // memory: wait mem_wait cycles from the start of a request, then ack
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = $urandom_range(wmax, wmin);
        mem_addr = imem_addr;
      end else begin
        check("addr_hold", imem_addr, mem_addr);
      end
      if (mem_wait == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem[imem_addr];
        mem_busy = 0;
      end else begin
        mem_wait--;
      end
    end else begin
      mem_busy = 0;
    end
    // decode sink and redirect source
    rdy = ($urandom_range(0, 99) < ready_pct);
    br = 0;
    case ($urandom_range(0, 3))
      0: tgt = 9'h1FF;
      1: tgt = 9'h000;
      default: tgt = AW'($urandom);
    endcase
    if (br_mode == 0) begin
      br = ($urandom_range(0, 99) < br_pct);
    end else if (br_mode == 1) begin
      if (m_boot && !m_buf && !m_sq && pc_in == 9'h010 && !imem_ack) begin
        br = 1; tgt = 9'h040; br_mode = 0; fired = 1;
      end
    end else begin
      if (m_buf) begin
        br = 1; tgt = 9'h1FF; rdy = 0; br_mode = 0; fired = 1;
      end
    end
    inst_ready = rdy;
    br_valid = br;
    br_target = tgt;
    #1;
    // expected combinational outputs
    e_req = 1'b0; e_addr = '0; e_npc = pc_in;
    if (!m_boot) begin
      e_npc = pc_in + 9'd1;
    end else if (m_buf) begin
      if (br) e_npc = tgt;
    end else if (m_sq) begin
      e_req = 1'b1; e_addr = m_sq_addr;
      if (br) e_npc = tgt;
    end else begin
      e_req = 1'b1; e_addr = pc_in;
      if (br) e_npc = tgt;
      else if (imem_ack) e_npc = pc_in + 9'd1;
    end
    check("npc_out", npc_out, e_npc);
    check("imem_req", imem_req, e_req);
    if (e_req) check("imem_addr", imem_addr, e_addr);
    check("inst_valid", inst_valid, m_buf);
    check("inst_out", inst_out, m_out);
    check("inst_pc", inst_pc, m_pc);
`ifdef FETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, m_fetch);
    check("perf_squash", perf_squash_cnt, m_squash);
`endif
    // scoreboard: each decode transfer must deliver the oldest loaded instruction
    if (inst_valid && rdy) begin
      check("sb_size", exp_q.size(), 1);
      if (exp_q.size() > 0) check("sb_inst", {inst_pc, inst_out}, exp_q.pop_front());
      if (inst_pc == 9'h040) saw_040 = 1;
      if (inst_pc == 9'h1FF) saw_1ff = 1;
      if (inst_pc == 9'h000 && saw_1ff) saw_wrap = 1;
    end
    // model state update
    if (!m_boot) begin
      m_boot = 1;
    end else if (m_buf) begin
      if (rdy) begin
        m_fetch = sat_inc(m_fetch);
      end else if (br) begin
        m_squash = sat_inc(m_squash);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
      if (rdy || br) m_buf = 0;
    end else if (m_sq) begin
      if (imem_ack) begin
        m_sq = 0;
        m_squash = sat_inc(m_squash);
      end
    end else if (imem_ack && !br) begin
      m_buf = 1; m_out = imem_rdata; m_pc = pc_in;
      exp_q.push_back({pc_in, imem_rdata});
    end else if (imem_ack) begin
      m_squash = sat_inc(m_squash);
    end else if (br) begin
      m_sq = 1; m_sq_addr = pc_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int w0, input int w1, input int rp, input int bp);
    wmin = w0; wmax = w1; ready_pct = rp; br_pct = bp;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = $urandom;
    br_mode = 0; fired = 0;
    #2;
    apply_reset(2);

    // zero-wait memory, decode always ready: 0x000, 0x001, 0x002, ...
    run(20, 0, 0, 100, 0);
    // three wait states per read
    run(30, 3, 3, 100, 0);
    // decode stalls in DELIVER, then releases
    run(12, 0, 0, 0, 0);
    run(10, 0, 0, 100, 0);

    // reset asserted while a read is pending
    begin
      int n = 0;
      wmin = 3; wmax = 3;
      while (!(m_boot && !m_buf && !m_sq) && n < 20) begin
        cycle();
        n++;
      end
      check("reach_fetch", m_boot && !m_buf && !m_sq, 1);
      #2;
      apply_reset(2);
    end

    // redirect to 0x040 while the read of 0x010 waits for its ack
    fired = 0; saw_040 = 0; br_mode = 1;
    run(100, 2, 2, 100, 0);
    check("br_fetch_fired", fired, 1);
    check("br_fetch_target", saw_040, 1);

    // redirect to 0x1FF while an instruction sits in the buffer, then wrap
    fired = 0; saw_1ff = 0; saw_wrap = 0; br_mode = 2;
    run(20, 0, 0, 100, 0);
    check("br_deliver_fired", fired, 1);
    check("br_deliver_wrap", saw_wrap, 1);

    // randomized traffic
    br_mode = 0;
    run(2000, 0, 3, 60, 10);
    run(500, 0, 1, 90, 25);
    check("sb_left", exp_q.size(), m_buf ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
